fetch_prefetch_stage: RTL and testbench

FETCH_PREFETCH_STAGE -- requirements
Module: fetch_prefetch_stage

---
 rtl/fetch_prefetch_stage.sv | 205 ++++++++++++++++++++
 tb/tb_fetch_prefetch_stage.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_prefetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_prefetch_stage
//
// Instruction fetch front end. It holds a small synchronous program memory
// and a prefetch queue. While running, it reads sequential addresses from the
// memory into the queue and hands the oldest entry to a valid/ready consumer.
//
// Ports
//   clk           single clock; all state updates on the rising edge
//   reset         asynchronous, active-high reset
//   fetch_en      1 = fetch (FETCH state), 0 = idle (IDLE state)
//   pc_load       redirect: flush the queue, drop any in-flight read, pc <= addr
//   pc_load_addr  redirect target
//   pm_wr         program-memory write strobe
//   pm_wr_addr    program-memory write address
//   pm_wr_data    program-memory write data
//   out_valid     queue head holds an instruction
//   out_ready     consumer accepts the head
//   out_inst      head instruction
//   out_pc        address the head was fetched from
//   out_perr      head parity error (always 0 unless FETCH_PARITY_EN)
//
// Build option
//   FETCH_PARITY_EN  when defined, each memory word gets one even-parity bit.
//                    The bit is computed at write time and rechecked when the
//                    word is pushed into the queue.
// ---------------------------------------------------------------------------
module fetch_prefetch_stage #(
    parameter int unsigned INST_W   = 68,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned FQ_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_en,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_load_addr,
    input  logic              pm_wr,
    input  logic [ADDR_W-1:0] pm_wr_addr,
    input  logic [INST_W-1:0] pm_wr_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_W-1:0] out_inst,
    output logic [ADDR_W-1:0] out_pc,
    output logic              out_perr
);

    localparam int unsigned MEM_DEPTH = 1 << ADDR_W;
    localparam int unsigned PTR_W     = $clog2(FQ_DEPTH);
    localparam int unsigned CNT_W     = PTR_W + 1;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_FETCH = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              inflight_q, inflight_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;

    logic [INST_W-1:0] mem_q [MEM_DEPTH];
    logic [INST_W-1:0] rd_data_q;
    logic [ADDR_W-1:0] rd_pc_q;

    logic [INST_W-1:0] fq_inst_q [FQ_DEPTH];
    logic [ADDR_W-1:0] fq_pc_q   [FQ_DEPTH];

    logic issue;
    logic push;
    logic pop;

    // -----------------------------------------------------------------------
    // Control
    // -----------------------------------------------------------------------
    always_comb begin
        // Credit rule: a read is only issued if its result is guaranteed a
        // free slot. Any pop on this edge is ignored, so the queue can never
        // overflow.
        issue = (state_q == ST_FETCH) && !pc_load &&
                ((count_q + CNT_W'(inflight_q)) < CNT_W'(FQ_DEPTH));
        // A redirect discards the read that is landing this cycle.
        push  = inflight_q && !pc_load;
        pop   = out_valid && out_ready && !pc_load;

        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (fetch_en)  state_d = ST_FETCH;
            ST_FETCH: if (!fetch_en) state_d = ST_IDLE;
            default:                 state_d = ST_IDLE;
        endcase

        inflight_d = issue;

        if (pc_load) begin
            pc_d = pc_load_addr;
        end else if (issue) begin
            pc_d = pc_q + 1'b1;
        end else begin
            pc_d = pc_q;
        end

        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (pc_load) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            pc_q       <= '0;
            inflight_q <= 1'b0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    // -----------------------------------------------------------------------
    // Program memory. It has no reset, so its contents survive reset. Both
    // accesses are non-blocking, so a same-address read and write on one
    // edge return the old word.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (pm_wr) begin
            mem_q[pm_wr_addr] <= pm_wr_data;
        end
        if (issue) begin
            rd_data_q <= mem_q[pc_q];
            rd_pc_q   <= pc_q;
        end
    end

    // Queue storage. Only entries below count are ever observed, so the
    // storage needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            fq_inst_q[wr_ptr_q] <= rd_data_q;
            fq_pc_q[wr_ptr_q]   <= rd_pc_q;
        end
    end

    // The head fields are gated by valid so that the outputs read zero
    // during and after reset.
    always_comb begin
        out_valid = (count_q != '0);
        out_inst  = out_valid ? fq_inst_q[rd_ptr_q] : '0;
        out_pc    = out_valid ? fq_pc_q[rd_ptr_q]   : '0;
    end

`ifdef FETCH_PARITY_EN
    logic mem_par_q [MEM_DEPTH];
    logic rd_par_q;
    logic fq_perr_q [FQ_DEPTH];
    logic push_perr;

    always_ff @(posedge clk) begin
        if (pm_wr) begin
            mem_par_q[pm_wr_addr] <= ^pm_wr_data;
        end
        if (issue) begin
            rd_par_q <= mem_par_q[pc_q];
        end
    end

    always_comb begin
        push_perr = (^rd_data_q) != rd_par_q;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fq_perr_q[wr_ptr_q] <= push_perr;
        end
    end

    always_comb begin
        out_perr = out_valid && fq_perr_q[rd_ptr_q];
    end
`else
    always_comb begin
        out_perr = 1'b0;
    end
`endif

endmodule

// File: tb/tb_fetch_prefetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_prefetch_stage
//
// Directed bench for fetch_prefetch_stage with the default parameters
// (INST_W=68, ADDR_W=5, FQ_DEPTH=4). Inputs are driven just after each
// falling edge and outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fetch_prefetch_stage;

    localparam int INST_W   = 68;
    localparam int ADDR_W   = 5;
    localparam int FQ_DEPTH = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              fetch_en;
    logic              pc_load;
    logic [ADDR_W-1:0] pc_load_addr;
    logic              pm_wr;
    logic [ADDR_W-1:0] pm_wr_addr;
    logic [INST_W-1:0] pm_wr_data;
    logic              out_valid;
    logic              out_ready;
    logic [INST_W-1:0] out_inst;
    logic [ADDR_W-1:0] out_pc;
    logic              out_perr;

    int checks   = 0;
    int failures = 0;

    // Expected head pc while streaming.
    logic [ADDR_W-1:0] exp_pc;
    logic [INST_W-1:0] exp_inst;

    fetch_prefetch_stage #(
        .INST_W  (INST_W),
        .ADDR_W  (ADDR_W),
        .FQ_DEPTH(FQ_DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .fetch_en    (fetch_en),
        .pc_load     (pc_load),
        .pc_load_addr(pc_load_addr),
        .pm_wr       (pm_wr),
        .pm_wr_addr  (pm_wr_addr),
        .pm_wr_data  (pm_wr_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_inst    (out_inst),
        .out_pc      (out_pc),
        .out_perr    (out_perr)
    );

    always #5 clk = ~clk;

    // A push into a full queue shows up as count exceeding the depth.
    always @(negedge clk) begin
        if (!reset) begin
            checks++;
            assert (int'(dut.count_q) <= FQ_DEPTH) else begin
                $display("FAIL overflow count=%0d max=%0d", dut.count_q, FQ_DEPTH);
                failures++;
            end
        end
    end

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b1; fetch_en = 1'b0; pc_load = 1'b0; pc_load_addr = '0;
        pm_wr = 1'b0; pm_wr_addr = '0; pm_wr_data = '0; out_ready = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin $display("FAIL rst_valid got=%0h exp=0", out_valid); failures++; end
        checks++; if (out_inst !== '0) begin $display("FAIL rst_inst got=%0h exp=0", out_inst); failures++; end
        checks++; if (out_pc !== '0) begin $display("FAIL rst_pc got=%0h exp=0", out_pc); failures++; end
        checks++; if (out_perr !== 1'b0) begin $display("FAIL rst_perr got=%0h exp=0", out_perr); failures++; end
        checks++; if (dut.pc_q !== '0) begin $display("FAIL rst_int_pc got=%0h exp=0", dut.pc_q); failures++; end
        cyc(3);
        reset = 1'b0;
        // Preload mem[k] = k + 0x100 while idle.
        for (int k = 0; k < (1 << ADDR_W); k++) begin
            pm_wr = 1'b1; pm_wr_addr = ADDR_W'(k); pm_wr_data = INST_W'(k + 'h100);
            cyc(1);
        end
        pm_wr = 1'b0;
        cyc(2);
        checks++; if (out_valid !== 1'b0) begin $display("FAIL idle_no_fetch got=%0h exp=0", out_valid); failures++; end
    endtask

    task automatic test_stream;
        fetch_en = 1'b1; out_ready = 1'b1;
        cyc(1); // state enters FETCH
        checks++; if (out_valid !== 1'b0) begin $display("FAIL lat1_valid got=%0h exp=0", out_valid); failures++; end
        cyc(1); // first issue
        checks++; if (out_valid !== 1'b0) begin $display("FAIL lat2_valid got=%0h exp=0", out_valid); failures++; end
        cyc(1); // first push
        exp_pc = '0;
        for (int i = 0; i < 12; i++) begin
            exp_inst = INST_W'(exp_pc) + INST_W'('h100);
            checks++; if (out_valid !== 1'b1) begin $display("FAIL stream_valid[%0d] got=%0h exp=1", i, out_valid); failures++; end
            checks++; if (out_pc !== exp_pc) begin $display("FAIL stream_pc[%0d] got=%0h exp=%0h", i, out_pc, exp_pc); failures++; end
            checks++; if (out_inst !== exp_inst) begin $display("FAIL stream_inst[%0d] got=%0h exp=%0h", i, out_inst, exp_inst); failures++; end
            checks++; if (out_perr !== 1'b0) begin $display("FAIL stream_perr[%0d] got=%0h exp=0", i, out_perr); failures++; end
            cyc(1);
            exp_pc = exp_pc + 1'b1;
        end
    endtask

    task automatic test_backpressure;
        out_ready = 1'b0;
        cyc(10);
        checks++; if (int'(dut.count_q) !== FQ_DEPTH) begin $display("FAIL bp_count got=%0d exp=%0d", dut.count_q, FQ_DEPTH); failures++; end
        checks++; if (out_pc !== exp_pc) begin $display("FAIL bp_head_held got=%0h exp=%0h", out_pc, exp_pc); failures++; end
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp_inst = INST_W'(exp_pc) + INST_W'('h100);
            checks++; if (out_valid !== 1'b1) begin $display("FAIL bp_valid[%0d] got=%0h exp=1", i, out_valid); failures++; end
            checks++; if (out_pc !== exp_pc) begin $display("FAIL bp_pc[%0d] got=%0h exp=%0h", i, out_pc, exp_pc); failures++; end
            checks++; if (out_inst !== exp_inst) begin $display("FAIL bp_inst[%0d] got=%0h exp=%0h", i, out_inst, exp_inst); failures++; end
            cyc(1);
            exp_pc = exp_pc + 1'b1;
        end
    endtask

    // Fill the queue, then redirect with out_ready=1 on the same edge.
    task automatic test_redirect(input logic [ADDR_W-1:0] addr);
        out_ready = 1'b0;
        cyc(6);
        checks++; if (int'(dut.count_q) !== FQ_DEPTH) begin $display("FAIL rd_full got=%0d exp=%0d", dut.count_q, FQ_DEPTH); failures++; end
        out_ready = 1'b1; pc_load = 1'b1; pc_load_addr = addr;
        cyc(1);
        pc_load = 1'b0;
        checks++; if (out_valid !== 1'b0) begin $display("FAIL rd_flush_valid got=%0h exp=0", out_valid); failures++; end
        cyc(1);
        checks++; if (out_valid !== 1'b0) begin $display("FAIL rd_issue_valid got=%0h exp=0", out_valid); failures++; end
        cyc(1);
        exp_pc = addr;
        for (int i = 0; i < 4; i++) begin
            exp_inst = INST_W'(exp_pc) + INST_W'('h100);
            checks++; if (out_pc !== exp_pc) begin $display("FAIL rd_pc[%0d] got=%0h exp=%0h", i, out_pc, exp_pc); failures++; end
            checks++; if (out_inst !== exp_inst) begin $display("FAIL rd_inst[%0d] got=%0h exp=%0h", i, out_inst, exp_inst); failures++; end
            cyc(1);
            exp_pc = exp_pc + 1'b1;
        end
    endtask

    task automatic test_rw_collision;
        out_ready = 1'b1; pc_load = 1'b1; pc_load_addr = 5'd5;
        cyc(1);
        pc_load = 1'b0;
        pm_wr = 1'b1; pm_wr_addr = 5'd5; pm_wr_data = INST_W'('hABC);
        cyc(1); // read of 5 and write of 5 on the same edge
        pm_wr = 1'b0;
        cyc(1);
        checks++; if (out_pc !== 5'd5) begin $display("FAIL col_old_pc got=%0h exp=5", out_pc); failures++; end
        checks++; if (out_inst !== INST_W'('h105)) begin $display("FAIL col_old_inst got=%0h exp=105", out_inst); failures++; end
        pc_load = 1'b1; pc_load_addr = 5'd5;
        cyc(1);
        pc_load = 1'b0;
        cyc(2);
        checks++; if (out_pc !== 5'd5) begin $display("FAIL col_new_pc got=%0h exp=5", out_pc); failures++; end
        checks++; if (out_inst !== INST_W'('hABC)) begin $display("FAIL col_new_inst got=%0h exp=abc", out_inst); failures++; end
    endtask

    // Head is pc 5 on entry; idling holds it and then no new reads appear.
    task automatic test_idle;
        out_ready = 1'b0; fetch_en = 1'b0;
        cyc(6);
        checks++; if (out_valid !== 1'b1) begin $display("FAIL idle_hold_valid got=%0h exp=1", out_valid); failures++; end
        checks++; if (out_pc !== 5'd5) begin $display("FAIL idle_hold_pc got=%0h exp=5", out_pc); failures++; end
        out_ready = 1'b1;
        cyc(8);
        checks++; if (out_valid !== 1'b0) begin $display("FAIL idle_drain got=%0h exp=0", out_valid); failures++; end
        cyc(4);
        checks++; if (out_valid !== 1'b0) begin $display("FAIL idle_stays_empty got=%0h exp=0", out_valid); failures++; end
    endtask

`ifdef FETCH_PARITY_EN
    task automatic test_parity;
        dut.mem_q[3] = dut.mem_q[3] ^ INST_W'(1);
        fetch_en = 1'b1; out_ready = 1'b1; pc_load = 1'b1; pc_load_addr = '0;
        cyc(1);
        pc_load = 1'b0;
        cyc(2);
        exp_pc = '0;
        for (int i = 0; i < 6; i++) begin
            checks++; if (out_pc !== exp_pc) begin $display("FAIL par_pc[%0d] got=%0h exp=%0h", i, out_pc, exp_pc); failures++; end
            checks++; if (out_perr !== (exp_pc == 5'd3)) begin $display("FAIL par_perr[%0d] got=%0h exp=%0h", i, out_perr, (exp_pc == 5'd3)); failures++; end
            cyc(1);
            exp_pc = exp_pc + 1'b1;
        end
        fetch_en = 1'b0;
        cyc(8);
    endtask
`endif

    task automatic test_reset_mid;
        fetch_en = 1'b1; out_ready = 1'b1;
        cyc(5);
        #2 reset = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin $display("FAIL mid_rst_valid got=%0h exp=0", out_valid); failures++; end
        checks++; if (out_inst !== '0) begin $display("FAIL mid_rst_inst got=%0h exp=0", out_inst); failures++; end
        checks++; if (out_pc !== '0) begin $display("FAIL mid_rst_pc got=%0h exp=0", out_pc); failures++; end
        checks++; if (out_perr !== 1'b0) begin $display("FAIL mid_rst_perr got=%0h exp=0", out_perr); failures++; end
        checks++; if (dut.pc_q !== '0) begin $display("FAIL mid_rst_int_pc got=%0h exp=0", dut.pc_q); failures++; end
        cyc(2);
        reset = 1'b0; fetch_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            checks++; if (out_valid !== 1'b0) begin $display("FAIL mid_no_stale[%0d] got=%0h exp=0", i, out_valid); failures++; end
        end
        fetch_en = 1'b1;
        cyc(3);
        checks++; if (out_valid !== 1'b1) begin $display("FAIL restart_valid got=%0h exp=1", out_valid); failures++; end
        checks++; if (out_pc !== '0) begin $display("FAIL restart_pc got=%0h exp=0", out_pc); failures++; end
        checks++; if (out_inst !== INST_W'('h100)) begin $display("FAIL restart_inst got=%0h exp=100", out_inst); failures++; end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect(5'd20);
        test_redirect(5'd30);
        test_rw_collision();
        test_idle();
`ifdef FETCH_PARITY_EN
        test_parity();
`endif
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        failures++;
        $display("FAIL timeout got=running exp=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
